// File: rtl/fft_pkg.sv
// Shared types, widths and the round-half-even / saturate helper for the
// complex-multiply combine stage.
package fft_pkg;

  localparam int unsigned PROD_W     = 35;
  localparam int unsigned FRAC_SHIFT = 15;
  localparam int unsigned OUT_W      = 20;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned SUM_W = PROD_W + 1;
  localparam int unsigned EXT_W = PROD_W + 2;
  localparam int unsigned Q_W   = EXT_W - FRAC_SHIFT;
  localparam int unsigned RND   = (1 << (FRAC_SHIFT - 1)) - 1;

  localparam logic signed [Q_W-1:0] Q_MAX = Q_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [Q_W-1:0] Q_MIN = Q_W'(-(2 ** (OUT_W - 1)));

  typedef logic signed [OUT_W-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_out_t;

  typedef struct packed {
    sample_t val;
    logic    sat;
  } rs_t;

  // The extra headroom bit keeps the rounding add from wrapping.
  function automatic rs_t round_sat(input logic signed [SUM_W-1:0] x);
    logic [EXT_W-1:0]        sum;
    logic signed [Q_W-1:0]   q;
    rs_t                     r;
    sum = {x[SUM_W-1], x} + EXT_W'(RND) + EXT_W'(x[FRAC_SHIFT]);
    q   = $signed(sum[EXT_W-1:FRAC_SHIFT]);
    r.sat = 1'b0;
    r.val = sample_t'(q);
    if (q > Q_MAX) begin
      r.val = sample_t'(Q_MAX);
      r.sat = 1'b1;
    end else if (q < Q_MIN) begin
      r.val = sample_t'(Q_MIN);
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_cmul_combine_round_if.sv
// Product-set input stream, rounded result output stream and overflow monitor.
interface fft_cmul_combine_round_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] p_rr;
  logic signed [PROD_W-1:0] p_ii;
  logic signed [PROD_W-1:0] p_ri;
  logic signed [PROD_W-1:0] p_ir;
  logic                     out_valid;
  logic                     out_ready;
  sample_t                  out_re;
  sample_t                  out_im;
  logic                     sat_flag;
  logic [CNT_W-1:0]         ovf_count;
  logic                     ovf_clear;

  modport master (
    output in_valid, p_rr, p_ii, p_ri, p_ir, out_ready, ovf_clear,
    input  in_ready, out_valid, out_re, out_im, sat_flag, ovf_count
  );

  modport slave (
    input  in_valid, p_rr, p_ii, p_ri, p_ir, out_ready, ovf_clear,
    output in_ready, out_valid, out_re, out_im, sat_flag, ovf_count
  );

endinterface

// File: rtl/fft_round_sat.sv
// Combinational round-half-even, FRAC_SHIFT drop and clamp to OUT_W.
module fft_round_sat
  import fft_pkg::*;
(
  input  logic signed [SUM_W-1:0] x_i,
  output sample_t                 y_o,
  output logic                    sat_o
);

  rs_t rs;

  always_comb begin
    rs = round_sat(x_i);
  end

  assign y_o   = rs.val;
  assign sat_o = rs.sat;

endmodule

// File: rtl/fft_cmul_combine_round.sv
// Two-stage combine (rr-ii, ri+ir) then round/saturate pipeline with a
// collapsing valid/ready handshake and a sticky saturation event counter.
module fft_cmul_combine_round
  import fft_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  fft_cmul_combine_round_if.slave bus
);

  logic                    s1_valid_q;
  logic signed [SUM_W-1:0] s1_re_q;
  logic signed [SUM_W-1:0] s1_im_q;
  logic                    s2_valid_q;
  cplx_out_t               s2_q;
  logic                    s2_sat_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  logic    s2_load;
  logic    in_fire;
  logic    out_fire;
  sample_t re_rnd;
  sample_t im_rnd;
  logic    re_sat;
  logic    im_sat;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_load;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = s2_valid_q && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_re_q    <= {bus.p_rr[PROD_W-1], bus.p_rr} - {bus.p_ii[PROD_W-1], bus.p_ii};
      s1_im_q    <= {bus.p_ri[PROD_W-1], bus.p_ri} + {bus.p_ir[PROD_W-1], bus.p_ir};
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  fft_round_sat u_rs_re (
    .x_i   (s1_re_q),
    .y_o   (re_rnd),
    .sat_o (re_sat)
  );

  fft_round_sat u_rs_im (
    .x_i   (s1_im_q),
    .y_o   (im_rnd),
    .sat_o (im_sat)
  );

  // Data only moves on a real S1 item so a stalled result stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_sat_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_q.re  <= re_rnd;
        s2_q.im  <= im_rnd;
        s2_sat_q <= re_sat | im_sat;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.ovf_clear) begin
      cnt_d = '0;
    end else if (out_fire && s2_sat_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_re    = s2_q.re;
  assign bus.out_im    = s2_q.im;
  assign bus.sat_flag  = s2_sat_q;
  assign bus.ovf_count = cnt_q;

endmodule

// File: tb/tb_fft_cmul_combine_round.sv
// Bench for fft_cmul_combine_round: directed cases plus random traffic scored
// against an arithmetic round-half-even reference.
module tb_fft_cmul_combine_round;
  import fft_pkg::*;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
  } exp_t;

  logic clk;
  logic reset;
  fft_cmul_combine_round_if bus ();

  fft_cmul_combine_round dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t   q[$];
  longint cnt_m;
  int     vecs;
  int     errs;

  localparam longint CNT_MAX = (longint'(1) <<< CNT_W) - 1;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_round(input longint x, output longint v, output bit s);
    longint unit, fl, rem, hi, lo;
    unit = longint'(1) <<< FRAC_SHIFT;
    fl   = x >>> FRAC_SHIFT;
    rem  = x - fl * unit;
    if (rem * 2 > unit || (rem * 2 == unit && fl % 2 != 0)) fl++;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(hi + 1);
    s  = 1'b0;
    v  = fl;
    if (fl > hi) begin
      v = hi;
      s = 1'b1;
    end else if (fl < lo) begin
      v = lo;
      s = 1'b1;
    end
  endfunction

  function automatic exp_t model(input longint rr, input longint ii, input longint ri,
                                 input longint ir);
    exp_t   e;
    longint vr, vi;
    bit     sr, si;
    ref_round(rr - ii, vr, sr);
    ref_round(ri + ir, vi, si);
    e.re  = vr;
    e.im  = vi;
    e.sat = sr | si;
    return e;
  endfunction

  function automatic longint rprod();
    logic [63:0] r;
    longint      v;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0:       v = longint'(r >> 40);
      1:       v = longint'(r >> 31);
      default: v = longint'(r >> 30);
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    if (v < -(longint'(1) <<< (PROD_W - 1))) v = -(longint'(1) <<< (PROD_W - 1));
    return v;
  endfunction

  task automatic set_in(input longint rr, input longint ii, input longint ri,
                        input longint ir);
    bus.p_rr = PROD_W'(rr);
    bus.p_ii = PROD_W'(ii);
    bus.p_ri = PROD_W'(ri);
    bus.p_ir = PROD_W'(ir);
  endtask

  // One clock: score everything visible at the falling edge, then advance.
  task automatic clk_cycle(output bit acc);
    exp_t e;
    bit   fire_o;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
    chk("ovf_count", bus.ovf_count, cnt_m);
    if (q.size() == 0) chk("idle_valid", bus.out_valid, 0);
    if (q.size() == 2) chk("full_valid", bus.out_valid, 1);
    fire_o = 1'b0;
    e      = '{re: 0, im: 0, sat: 1'b0};
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", bus.out_valid, 0);
      end else begin
        e = q[0];
        chk("out_re", bus.out_re, e.re);
        chk("out_im", bus.out_im, e.im);
        chk("sat_flag", bus.sat_flag, e.sat);
        if (bus.out_ready) begin
          fire_o = 1'b1;
          void'(q.pop_front());
        end
      end
    end
    if (bus.ovf_clear) cnt_m = 0;
    else if (fire_o && e.sat && cnt_m != CNT_MAX) cnt_m++;
    if (acc) q.push_back(model(longint'(bus.p_rr), longint'(bus.p_ii),
                               longint'(bus.p_ri), longint'(bus.p_ir)));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint rr, input longint ii, input longint ri,
                      input longint ir);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    set_in(rr, ii, ri, ir);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      clk_cycle(acc);
      n++;
    end
    if (!acc) chk("send_timeout", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      clk_cycle(acc);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic directed(input string tag, input longint rr, input longint ii,
                          input longint ri, input longint ir, input longint ere,
                          input longint eim, input bit esat);
    bit acc;
    bus.out_ready = 1'b1;
    send(rr, ii, ri, ir);
    chk({tag, "_lat1"}, bus.out_valid, 0);
    clk_cycle(acc);
    chk({tag, "_lat2"}, bus.out_valid, 1);
    chk({tag, "_re"}, bus.out_re, ere);
    chk({tag, "_im"}, bus.out_im, eim);
    chk({tag, "_sat"}, bus.sat_flag, esat);
    drain();
  endtask

  localparam longint P34 = longint'(1) <<< 34;
  localparam longint P14 = longint'(1) <<< 14;

  initial begin
    bit     acc;
    int     idx;
    int     n;
    longint bp[5][4];

    vecs = 0;
    errs = 0;
    cnt_m = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clear = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_re", bus.out_re, 0);
    chk("rst_out_im", bus.out_im, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    chk("rst_ovf_count", bus.ovf_count, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    directed("unity", longint'(1) <<< 30, 0, 0, 0, 32768, 0, 1'b0);
    directed("rnd_3", 0, 0, 3 * P14, 0, 0, 2, 1'b0);
    directed("rnd_1", 0, 0, P14, 0, 0, 0, 1'b0);
    directed("rnd_5", 0, 0, 5 * P14, 0, 0, 2, 1'b0);
    directed("rnd_m3", 0, 0, -3 * P14, 0, 0, -2, 1'b0);
    directed("sat_pos", P34 - 1, -P34, 0, 0, 524287, 0, 1'b1);
    chk("sat_pos_cnt", bus.ovf_count, 1);
    directed("sat_neg", -P34, P34 - 1, 0, 0, -524288, 0, 1'b1);
    directed("neg_bound", -P34, 0, 0, 0, -524288, 0, 1'b0);

    // Backpressure: only two sets fit while the consumer stalls.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4; j++) bp[i][j] = rprod();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      set_in(bp[idx][0], bp[idx][1], bp[idx][2], bp[idx][3]);
      clk_cycle(acc);
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    n = 0;
    while (idx < 5 && n < 20) begin
      set_in(bp[idx][0], bp[idx][1], bp[idx][2], bp[idx][3]);
      clk_cycle(acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_all_in", idx, 5);
    bus.in_valid = 1'b0;
    drain();

    // Clear-vs-increment priority on the counter.
    bus.ovf_clear = 1'b1;
    clk_cycle(acc);
    bus.ovf_clear = 1'b0;
    for (int k = 0; k < 3; k++) directed("preload", P34 - 1, -P34, 0, 0, 524287, 0, 1'b1);
    chk("preload_cnt", bus.ovf_count, 3);
    bus.out_ready = 1'b0;
    send(-P34, P34 - 1, 0, 0);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      clk_cycle(acc);
      n++;
    end
    chk("clr_wait", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    bus.ovf_clear = 1'b1;
    clk_cycle(acc);
    bus.ovf_clear = 1'b0;
    chk("clr_priority", bus.ovf_count, 0);

    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.ovf_clear = ($urandom_range(0, 49) == 0);
      set_in(rprod(), rprod(), rprod(), rprod());
      clk_cycle(acc);
    end
    bus.in_valid  = 1'b0;
    bus.ovf_clear = 1'b0;
    drain();

    // Asynchronous reset in the middle of a stalled burst.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      set_in(rprod(), rprod(), rprod(), rprod());
      clk_cycle(acc);
    end
    chk("pre_rst_valid", bus.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_cnt", bus.ovf_count, 0);
    q.delete();
    cnt_m = 0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    directed("post_rst", 0, 0, 3 * P14, 7 * P14, 0, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
